// File: rtl/fsqrt_iter_if.sv
// Operand/result handshake bundle for the iterative single-precision square-root unit.
interface fsqrt_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        invalid;
  logic        busy;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, invalid, busy
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, invalid, busy
  );
endinterface

// File: rtl/fsqrt_iter.sv
// Single-precision square root, round-to-nearest-even, restoring digit recurrence
// resolving ITER_BITS root bits per cycle; one operation in flight.
module fsqrt_iter #(
  parameter int ITER_BITS = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  fsqrt_iter_if.slave  bus
);

  if (!(ITER_BITS == 1 || ITER_BITS == 5)) begin : g_bad_iter_bits
    $error("fsqrt_iter: ITER_BITS must be 1 or 5");
  end

  localparam int          NSTEPS = 25 / ITER_BITS;
  localparam logic [4:0]  LAST   = 5'(NSTEPS - 1);

  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [49:0] rad, rad_n;
  logic [27:0] rem, rem_n;
  logic [24:0] root, root_n;
  logic [7:0]  exp_r;
  logic        spec_r;
  logic [31:0] spec_y;
  logic        spec_inv;
  logic [31:0] y_r;
  logic        inv_r;

  logic        is_special;
  logic [8:0]  exp_sum;
  logic [23:0] mant_in;
  logic [27:0] rem_sh, trial;

  // Round-to-nearest-even of the 24-bit root (hidden one dropped) into {exp, frac}.
  function automatic logic [30:0] round_rne(input logic [7:0] e, input logic [23:0] q,
                                            input logic sticky);
    logic        inc;
    logic [23:0] mant;
    logic [7:0]  e_o;
    inc  = q[0] & (sticky | q[1]);
    mant = {1'b0, q[23:1]} + {23'd0, inc};
    e_o  = e + {7'd0, mant[23]};
    return {e_o, mant[22:0]};
  endfunction

  assign is_special = (bus.x[30:23] == 8'h00) || (bus.x[30:23] == 8'hFF) || bus.x[31];
  // floor((E-127)/2)+127 == (E+127)>>1; the dropped LSB is exactly "unbiased exponent odd".
  assign exp_sum    = {1'b0, bus.x[30:23]} + 9'd127;
  assign mant_in    = {1'b1, bus.x[22:0]};

  always_comb begin
    rem_n  = rem;
    root_n = root;
    rad_n  = rad;
    rem_sh = '0;
    trial  = '0;
    for (int i = 0; i < ITER_BITS; i++) begin
      rem_sh = {rem_n[25:0], rad_n[49:48]};
      trial  = {1'b0, root_n, 2'b01};
      if (rem_sh >= trial) begin
        rem_n  = rem_sh - trial;
        root_n = {root_n[23:0], 1'b1};
      end else begin
        rem_n  = rem_sh;
        root_n = {root_n[23:0], 1'b0};
      end
      rad_n = {rad_n[47:0], 2'b00};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = is_special ? ROUND : ITER;
      ITER:    if (cnt == LAST)  state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == DONE);
    bus.invalid   = (state == DONE) && inv_r;
    bus.y         = y_r;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      exp_r    <= '0;
      spec_r   <= 1'b0;
      spec_y   <= '0;
      spec_inv <= 1'b0;
      y_r      <= '0;
      inv_r    <= 1'b0;
    end else begin
      case (state)
        // capture: radicand alignment, result exponent and special-operand decode
        IDLE: if (bus.in_valid) begin
          cnt    <= '0;
          rem    <= '0;
          root   <= '0;
          exp_r  <= exp_sum[8:1];
          rad    <= exp_sum[0] ? {mant_in, 26'd0} : {1'b0, mant_in, 25'd0};
          spec_r <= is_special;
          if (bus.x[30:23] == 8'h00) begin
            spec_y   <= {bus.x[31], 31'd0};
            spec_inv <= 1'b0;
          end else if (bus.x[31] || (bus.x[22:0] != 23'd0)) begin
            spec_y   <= 32'h7FC00000;
            spec_inv <= 1'b1;
          end else begin
            spec_y   <= 32'h7F800000;
            spec_inv <= 1'b0;
          end
        end
        ITER: begin
          rad  <= rad_n;
          rem  <= rem_n;
          root <= root_n;
          cnt  <= cnt + 5'd1;
        end
        // round and register the result held through DONE
        ROUND: begin
          y_r   <= spec_r ? spec_y : {1'b0, round_rne(exp_r, root[23:0], rem != 28'd0)};
          inv_r <= spec_r && spec_inv;
        end
        default: ;
      endcase
    end
  end

endmodule
